// File: rtl/pulse_period_meter_if.sv
// rtl/pulse_period_meter_if.sv - control and result signals of the pulse period meter
interface pulse_period_meter_if #(
   parameter int WIDTH = 26
);
   logic             enable;
   logic             sig_in;
   logic [WIDTH-1:0] period;
   logic [WIDTH-1:0] high_time;
   logic             valid;
   logic             timeout;

   modport master (
      output enable, sig_in,
      input  period, high_time, valid, timeout
   );

   modport slave (
      input  enable, sig_in,
      output period, high_time, valid, timeout
   );
endinterface

// File: rtl/pulse_period_meter.sv
// rtl/pulse_period_meter.sv - measures period and high time of a slow asynchronous input
module pulse_period_meter #(
   parameter int WIDTH   = 26,
   parameter int TIMEOUT = 2**26 - 1
) (
   input  logic                  clk,
   input  logic                  reset_n,
   pulse_period_meter_if.slave   bus
);
   localparam logic [WIDTH-1:0] TMAX = WIDTH'(TIMEOUT);
   localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

   typedef enum logic [1:0] {IDLE, ARM, HIGH, LOW} state_t;

   state_t           state, state_n;
   logic             s1, s2, s3;
   logic             rise, fall;
   logic [WIDTH-1:0] cnt, cnt_n;
   logic [WIDTH-1:0] hi_lat, hi_lat_n;
   logic [WIDTH-1:0] period_q, period_n;
   logic [WIDTH-1:0] high_q, high_n;
   logic             valid_q, valid_n;
   logic             timeout_q, timeout_n;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
         s3 <= 1'b0;
      end else begin
         s1 <= bus.sig_in;
         s2 <= s1;
         s3 <= s2;
      end
   end

   assign rise = s2 & ~s3;
   assign fall = ~s2 & s3;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         cnt       <= '0;
         hi_lat    <= '0;
         period_q  <= '0;
         high_q    <= '0;
         valid_q   <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state     <= state_n;
         cnt       <= cnt_n;
         hi_lat    <= hi_lat_n;
         period_q  <= period_n;
         high_q    <= high_n;
         valid_q   <= valid_n;
         timeout_q <= timeout_n;
      end
   end

   always_comb begin
      state_n   = state;
      cnt_n     = cnt;
      hi_lat_n  = hi_lat;
      period_n  = period_q;
      high_n    = high_q;
      valid_n   = 1'b0;
      timeout_n = 1'b0;
      if (!bus.enable) begin
         state_n = IDLE;
         cnt_n   = '0;
      end else begin
         case (state)
            IDLE: begin
               cnt_n   = '0;
               state_n = ARM;
            end
            ARM: begin
               if (rise) begin
                  state_n = HIGH;
                  cnt_n   = ONE;
               end
            end
            HIGH: begin
               if (fall) begin
                  state_n  = LOW;
                  hi_lat_n = cnt;
                  // saturate so a fall exactly at the limit still times out in LOW
                  cnt_n    = (cnt == TMAX) ? cnt : cnt + ONE;
               end else if (cnt == TMAX) begin
                  timeout_n = 1'b1;
                  state_n   = ARM;
                  cnt_n     = '0;
               end else begin
                  cnt_n = cnt + ONE;
               end
            end
            LOW: begin
               if (rise) begin
                  state_n  = HIGH;
                  period_n = cnt;
                  high_n   = hi_lat;
                  valid_n  = 1'b1;
                  cnt_n    = ONE;
               end else if (cnt == TMAX) begin
                  timeout_n = 1'b1;
                  state_n   = ARM;
                  cnt_n     = '0;
               end else begin
                  cnt_n = cnt + ONE;
               end
            end
            default: begin
               state_n = IDLE;
               cnt_n   = '0;
            end
         endcase
      end
   end

   assign bus.period    = period_q;
   assign bus.high_time = high_q;
   assign bus.valid     = valid_q;
   assign bus.timeout   = timeout_q;
endmodule

// File: tb/tb_pulse_period_meter.sv
// tb/tb_pulse_period_meter.sv - scoreboard bench for pulse_period_meter
module tb_pulse_period_meter;
   typedef struct {
      bit is_to;
      int p;
      int h;
      int at;
   } exp_t;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic enable = 1'b0;
   logic sig = 1'b0;
   logic sel = 1'b0;
   int   cyc = 0;
   int   total = 0;
   int   bad = 0;
   exp_t qa[$];
   exp_t qb[$];

   pulse_period_meter_if #(.WIDTH(26)) ia ();
   pulse_period_meter_if #(.WIDTH(26)) ib ();

   assign ia.enable = enable;
   assign ib.enable = enable;
   assign ia.sig_in = sel ? 1'b0 : sig;
   assign ib.sig_in = sel ? sig : 1'b0;

   pulse_period_meter #(.WIDTH(26), .TIMEOUT(50)) dut_a (
      .clk(clk), .reset_n(reset_n), .bus(ia)
   );
   pulse_period_meter #(.WIDTH(26), .TIMEOUT(20)) dut_b (
      .clk(clk), .reset_n(reset_n), .bus(ib)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input int obs, input int exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d cyc=%0d", tag, obs, exp, cyc);
      end
   endtask

   task automatic push(input bit b, input bit is_to, input int p, input int h, input int at);
      exp_t e;
      e.is_to = is_to;
      e.p = p;
      e.h = h;
      e.at = at;
      if (b) qb.push_back(e);
      else qa.push_back(e);
   endtask

   task automatic check_dut(input bit b, input logic v, input logic t,
                            input logic [25:0] p, input logic [25:0] h);
      exp_t e;
      if (v && t) chk("both_strobes", 1, 0);
      if (v || t) begin
         if ((b ? qb.size() : qa.size()) == 0) begin
            chk(b ? "unexpected_strobe_b" : "unexpected_strobe_a", 1, 0);
         end else begin
            e = b ? qb.pop_front() : qa.pop_front();
            chk("strobe_kind", int'(t), int'(e.is_to));
            chk("strobe_cycle", cyc, e.at);
            if (v) begin
               chk("period", int'(p), e.p);
               chk("high_time", int'(h), e.h);
            end
         end
      end
   endtask

   always @(negedge clk) begin
      check_dut(1'b0, ia.valid, ia.timeout, ia.period, ia.high_time);
      check_dut(1'b1, ib.valid, ib.timeout, ib.period, ib.high_time);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // the first rise of each burst only arms the meter
   task automatic wave(input int p, input int h, input int n, input bit b);
      for (int i = 0; i < n; i++) begin
         sig = 1'b1;
         if (i > 0) push(b, 1'b0, p, h, cyc + 3);
         repeat (h) step();
         sig = 1'b0;
         repeat (p - h) step();
      end
   endtask

   task automatic park();
      enable = 1'b0;
      repeat (3) step();
      enable = 1'b1;
      repeat (3) step();
   endtask

   task automatic drain();
      for (int i = 0; i < 200 && (qa.size() + qb.size()) != 0; i++) step();
      chk("drain", qa.size() + qb.size(), 0);
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_period_a"}, int'(ia.period), 0);
      chk({tag, "_high_a"}, int'(ia.high_time), 0);
      chk({tag, "_valid_a"}, int'(ia.valid), 0);
      chk({tag, "_timeout_a"}, int'(ia.timeout), 0);
      chk({tag, "_period_b"}, int'(ib.period), 0);
      chk({tag, "_high_b"}, int'(ib.high_time), 0);
   endtask

   initial begin
      int n;
      repeat (3) step();
      check_zero("reset");
      reset_n = 1'b1;
      enable = 1'b1;
      repeat (3) step();

      // steady square wave
      wave(10, 4, 5, 1'b0);
      drain();
      park();

      // stalled input times out, prior results held
      n = cyc;
      sig = 1'b1;
      push(1'b0, 1'b1, 0, 0, n + 53);
      repeat (60) step();
      chk("held_period_after_timeout", int'(ia.period), 10);
      chk("held_high_after_timeout", int'(ia.high_time), 4);
      sig = 1'b0;
      repeat (3) step();
      wave(8, 3, 2, 1'b0);
      drain();
      park();

      // period exactly at the limit, then one past it
      sel = 1'b1;
      repeat (3) step();
      wave(20, 5, 2, 1'b1);
      drain();
      park();
      n = cyc;
      sig = 1'b1;
      push(1'b1, 1'b1, 0, 0, n + 23);
      repeat (5) step();
      sig = 1'b0;
      repeat (16) step();
      sig = 1'b1;
      repeat (5) step();
      sig = 1'b0;
      drain();
      park();
      chk("held_period_b", int'(ib.period), 20);
      sel = 1'b0;
      repeat (3) step();

      // enable dropped mid-HIGH
      wave(12, 6, 2, 1'b0);
      sig = 1'b1;
      push(1'b0, 1'b0, 12, 6, cyc + 3);
      repeat (3) step();
      enable = 1'b0;
      repeat (3) step();
      sig = 1'b0;
      repeat (6) step();
      sig = 1'b1;
      repeat (6) step();
      sig = 1'b0;
      repeat (2) step();
      chk("held_period_disabled", int'(ia.period), 12);
      chk("held_high_disabled", int'(ia.high_time), 6);
      enable = 1'b1;
      repeat (4) step();
      wave(12, 6, 2, 1'b0);
      drain();
      park();

      // asynchronous reset in LOW
      wave(10, 4, 2, 1'b0);
      sig = 1'b1;
      push(1'b0, 1'b0, 10, 4, cyc + 3);
      repeat (4) step();
      sig = 1'b0;
      repeat (3) step();
      chk("pre_reset_period", int'(ia.period), 10);
      #2;
      reset_n = 1'b0;
      #1;
      check_zero("mid_reset");
      repeat (2) step();
      reset_n = 1'b1;
      repeat (3) step();
      wave(10, 4, 5, 1'b0);
      drain();
      park();

      // one-cycle high pulse
      wave(6, 1, 4, 1'b0);
      drain();
      repeat (5) step();
      chk("final_queue", qa.size() + qb.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/pulse_period_meter.md
# pulse_period_meter

Measures the period and high time of a slow, asynchronous digital input (wheel encoder, sonar echo, or any `clk_slow`-rate signal) in system-clock cycles. It does the inverse of the clock divider: it recovers a cycle count from a slow waveform instead of generating one. Results are presented with a one-cycle `valid` strobe to the control FSM. A saturation timeout flags a stalled or absent input.

## Interface

**Parameters**
- `WIDTH`, default 26: width of the cycle counter and of the result outputs.
- `TIMEOUT`, default 2^26-1: count at which a measurement is abandoned. Must satisfy 2 ≤ TIMEOUT ≤ 2^WIDTH-1.

**Ports**
- `clk` input, 1: system clock. The block uses one clock.
- `reset_n` input, 1: asynchronous, active-low reset.
- `enable` input, 1: measurement enable, synchronous to `clk`.
- `sig_in` input, 1: signal under measurement. It is asynchronous to `clk`.
- `period` output, WIDTH: cycles between the last two detected rising edges.
- `high_time` output, WIDTH: cycles from rising edge to falling edge in the last complete period.
- `valid` output, 1: one-cycle strobe. `period` and `high_time` were updated this cycle.
- `timeout` output, 1: one-cycle strobe. A measurement was abandoned at TIMEOUT.

## Operation

**Synchronizer and edge detect**
- `sig_in` passes through a 2-flop synchronizer, s1 then s2. A third flop s3 holds the previous value.
- `rise` = s2 & ~s3. `fall` = ~s2 & s3.
- All three flops reset to 0.
- A pulse or gap shorter than one `clk` period may be missed. This is accepted.

**State machine**
States are IDLE, ARM, HIGH and LOW. The internal counter is `cnt` (WIDTH bits) and the internal latch is `hi_lat` (WIDTH bits).
- **IDLE:** `cnt` = 0.
  - `enable` = 1 → ARM.
- **ARM:** wait for the first rising edge. No result is produced for this edge.
  - `rise` → HIGH, `cnt` ← 1.
- **HIGH:** `cnt` ← `cnt` + 1 each cycle.
  - `fall` → LOW, `hi_lat` ← `cnt`.
- **LOW:** `cnt` ← `cnt` + 1 each cycle.
  - `rise` → HIGH.
  - On that same edge: `period` ← `cnt`, `high_time` ← `hi_lat`, `valid` ← 1, `cnt` ← 1.
- **Timeout (HIGH or LOW):** when `cnt` == TIMEOUT and no edge is detected that cycle:
  - `timeout` ← 1 for one cycle.
  - → ARM, `cnt` ← 0.
  - `period` and `high_time` are unchanged.
- **Edge and timeout in the same cycle:** the edge wins. The measurement completes normally and `timeout` stays 0.
- **`enable` = 0 in any state:** → IDLE on the next edge, `cnt` ← 0.
  - An in-flight measurement is discarded, with no `valid` and no `timeout`.
  - `period` and `high_time` hold their last values.
- **Arithmetic:** `cnt` never exceeds TIMEOUT, so it cannot wrap.

**Reset values** (`reset_n` = 0, asynchronous): state IDLE, `cnt` = 0, `hi_lat` = 0, `period` = 0, `high_time` = 0, `valid` = 0, `timeout` = 0. Reset asserted mid-measurement discards it immediately.

## Timing

- All outputs are registered. There is no combinational path from input to output.
- **Input latency:** suppose a `sig_in` transition is stable before clock edge E0. It reaches s2 at E1, `rise`/`fall` is decoded in the cycle after E1, and the outputs update at E2. So `valid` is high in the cycle following E2, 2 edges after capture.
- **Period measure:** a sig_in period of P cycles (P ≥ 2) gives `period` = P.
- **High-time measure:** a high interval of H cycles (H ≥ 1) gives `high_time` = H.
- **Strobes:** `valid` and `timeout` are never high in the same cycle. Neither is ever high for more than 1 cycle.
- **Strobe spacing:** consecutive `valid` strobes are exactly P cycles apart for a steady input.
- **Timeout latency:** `timeout` asserts TIMEOUT+1 cycles after the last detected edge that set `cnt` ← 1.
- **After reset release:** the first possible `valid` comes after two detected rising edges.

## Test plan

1. **Steady square wave:** reset, `enable` = 1, `sig_in` with period 10 cycles and high 4 cycles, 5 periods.
   - No `valid` on the first rise.
   - Then `valid` every 10 cycles with `period` = 10, `high_time` = 4.
2. **Timeout:** TIMEOUT = 50, one rising edge, then `sig_in` held high.
   - `timeout` pulses once, 51 cycles after `rise`.
   - No `valid`; `period` and `high_time` keep prior values.
   - The next two rises (period 8, high 3) give `valid` with 8 and 3.
3. **Edge at the limit:** TIMEOUT = 20, `sig_in` period exactly 20.
   - `valid` with `period` = 20 and `timeout` = 0.
   - Period 21 gives `timeout` and no `valid`.
4. **Enable drop:** deassert `enable` mid-HIGH of a period-12 wave.
   - No strobe; outputs hold.
   - Re-enable: first `valid` after two rises, value 12.
5. **Reset mid-measurement:** assert `reset_n` = 0 asynchronously between clock edges in LOW.
   - All outputs go to 0 immediately.
   - After release, behaviour is identical to scenario 1.
6. **Narrow pulse:** period 6, high 1 cycle (aligned).
   - `period` = 6 and `high_time` = 1 every 6 cycles.
